// File: rtl/fp32_pkg.sv
// fp32_pkg: shared fp32/int32 constants and converter state encoding.
package fp32_pkg;
    localparam int          FP32_EXP_BIAS = 127;
    localparam logic [7:0]  FP32_EXP_MAX  = 8'd255;
    localparam int          FP32_MANT_W   = 23;
    localparam logic [31:0] INT32_MAX     = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN     = 32'h8000_0000;
    localparam logic [2:0]  ST_GET_A      = 3'd0;
    localparam logic [2:0]  ST_UNPACK     = 3'd1;
    localparam logic [2:0]  ST_SPECIAL    = 3'd2;
    localparam logic [2:0]  ST_CONVERT    = 3'd3;
    localparam logic [2:0]  ST_PACK       = 3'd4;
    localparam logic [2:0]  ST_PUT_Z      = 3'd5;
endpackage

// File: rtl/fp32_to_int32_converter_align_shifter.sv
// fp32_align_shifter: aligns a 24-bit significand to its integer part,
// returning the round guard bit and the sticky OR of the bits below it.
module fp32_align_shifter (
    input  logic [23:0]       i_mant,
    input  logic signed [9:0] i_exp,
    output logic [31:0]       o_int,
    output logic              o_guard,
    output logic              o_sticky
);
    logic signed [9:0] w_rsh;
    logic [47:0]       w_frac;
    assign w_rsh  = 10'sd23 - i_exp;
    assign w_frac = {i_mant, 24'd0} >> w_rsh;
    always_comb begin
        o_int    = '0;
        o_guard  = 1'b0;
        o_sticky = 1'b0;
        if (i_exp >= 10'sd23) begin
            o_int = {8'd0, i_mant} << (i_exp - 10'sd23);
        end else if (i_exp >= 10'sd0) begin
            o_int    = {8'd0, w_frac[47:24]};
            o_guard  = w_frac[23];
            o_sticky = |w_frac[22:0];
        end else begin
            // below 1.0 the hidden bit is the guard only when e = -1
            o_guard  = (i_exp == -10'sd1);
            o_sticky = (i_exp == -10'sd1) ? |i_mant[22:0] : 1'b1;
        end
    end
endmodule

// File: rtl/fp32_to_int32_converter.sv
// fp32_to_int32_converter: stb/ack handshaked fp32 -> int32 conversion with
// truncate or round-to-nearest-even, saturation and invalid/inexact flags.
module fp32_to_int32_converter #(
    parameter int ROUND_NEAREST = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_invalid,
    output logic        output_z_inexact,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    import fp32_pkg::*;

    logic [2:0]             r_state, w_next;
    logic [31:0]            r_a, r_mag, r_z;
    logic                   r_s, r_guard, r_sticky, r_inv, r_inx, r_stb, r_ack;
    logic [7:0]             r_exp;
    logic [FP32_MANT_W-1:0] r_m;
    logic signed [9:0]      r_e;
    logic [31:0]            w_int, w_sat, w_sp_z, w_pk_z;
    logic                   w_guard, w_sticky;
    logic                   w_nan, w_inf, w_big, w_min, w_zero, w_special;
    logic                   w_rnd, w_ovf, w_take;
    logic [32:0]            w_mag_r;

    fp32_align_shifter u_shift (
        .i_mant   ({1'b1, r_m}),
        .i_exp    (r_e),
        .o_int    (w_int),
        .o_guard  (w_guard),
        .o_sticky (w_sticky)
    );

    assign w_take    = r_ack && input_a_stb;
    assign w_nan     = (r_exp == FP32_EXP_MAX) && (r_m != '0);
    assign w_inf     = (r_exp == FP32_EXP_MAX);
    assign w_big     = (r_e >= 10'sd31);
    assign w_min     = r_s && (r_exp == 8'd158) && (r_m == '0);
    assign w_zero    = (r_exp == 8'd0);
    assign w_special = w_inf || w_big || w_zero;
    assign w_sat     = r_s ? INT32_MIN : INT32_MAX;
    assign w_sp_z    = w_nan ? INT32_MIN : (w_inf || w_big) ? w_sat : 32'd0;

    assign w_rnd   = (ROUND_NEAREST != 0) && r_guard && (r_sticky || r_mag[0]);
    assign w_mag_r = {1'b0, r_mag} + {32'd0, w_rnd};
    assign w_ovf   = !r_s && (w_mag_r > {1'b0, INT32_MAX});
    assign w_pk_z  = w_ovf ? INT32_MAX : r_s ? (~w_mag_r[31:0] + 32'd1) : w_mag_r[31:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_GET_A;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = ST_GET_A;
        case (r_state)
            ST_GET_A:   w_next = w_take ? ST_UNPACK : ST_GET_A;
            ST_UNPACK:  w_next = ST_SPECIAL;
            ST_SPECIAL: w_next = w_special ? ST_PUT_Z : ST_CONVERT;
            ST_CONVERT: w_next = ST_PACK;
            ST_PACK:    w_next = ST_PUT_Z;
            ST_PUT_Z:   w_next = (r_stb && output_z_ack) ? ST_GET_A : ST_PUT_Z;
            default:    w_next = ST_GET_A;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ack    <= 1'b0;
            r_stb    <= 1'b0;
            r_a      <= '0;
            r_s      <= 1'b0;
            r_exp    <= '0;
            r_m      <= '0;
            r_e      <= '0;
            r_mag    <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_z      <= '0;
            r_inv    <= 1'b0;
            r_inx    <= 1'b0;
        end else begin
            r_ack <= (r_state == ST_GET_A) && !w_take;
            r_stb <= (r_state == ST_SPECIAL && w_special) || (r_state == ST_PACK) ||
                     (r_state == ST_PUT_Z && !output_z_ack);
            if (r_state == ST_GET_A && w_take) r_a <= input_a;
            if (r_state == ST_UNPACK) begin
                r_s   <= r_a[31];
                r_exp <= r_a[30:23];
                r_m   <= r_a[22:0];
                r_e   <= $signed({2'b00, r_a[30:23]}) - 10'(FP32_EXP_BIAS);
            end
            if (r_state == ST_CONVERT) begin
                r_mag    <= w_int;
                r_guard  <= w_guard;
                r_sticky <= w_sticky;
            end
            if (r_state == ST_SPECIAL && w_special) begin
                r_z   <= w_sp_z;
                r_inv <= w_nan || w_inf || (w_big && !w_min);
                r_inx <= w_zero && (r_m != '0);
            end
            if (r_state == ST_PACK) begin
                r_z   <= w_pk_z;
                r_inv <= w_ovf;
                r_inx <= r_guard || r_sticky;
            end
        end
    end

    assign input_a_ack      = r_ack;
    assign output_z_stb     = r_stb;
    assign output_z         = r_z;
    assign output_z_invalid = r_inv;
    assign output_z_inexact = r_inx;
endmodule

// File: doc/fp32_to_int32_converter.md
Name: fp32_to_int32_converter

Overview:
- Converts an IEEE-754 single-precision value to a signed 32-bit two's-complement integer.
- Sits directly downstream of the fp32 multiplier. Its input port set mates 1:1 with the multiplier's output_z / output_z_stb / output_z_ack.
- Uses the same strobe/acknowledge handshake on both sides, so it can be chained into integer datapaths.
- Handles rounding, saturation and exception flags.

Parameters:
- ROUND_NEAREST, 0: 0 = truncate toward zero (C cast semantics); 1 = round to nearest, ties to even.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- input_a  input  32  fp32 operand.
- input_a_stb  input  1  producer has valid input_a.
- input_a_ack  output  1  converter ready to accept input_a.
- output_z  output  32  signed int32 result.
- output_z_invalid  output  1  NaN, infinity or out-of-range input; valid with output_z.
- output_z_inexact  output  1  result differs from the exact input value; valid with output_z.
- output_z_stb  output  1  output_z and flags valid.
- output_z_ack  input  1  consumer accepts output_z.

Behaviour:
- Reset is asynchronous and active-low. One clock domain.
- While reset = 0: state = get_a, input_a_ack = 0, output_z_stb = 0, output_z = 0, both flags = 0. This applies immediately, also mid-operation; an in-flight operand is discarded.
- States: get_a -> unpack -> special_cases -> convert -> pack -> put_z -> get_a.
- get_a:
  - input_a_ack is registered 1 on the first edge in get_a.
  - Transfer happens on the edge where input_a_ack = 1 and input_a_stb = 1. On that edge the operand is latched, input_a_ack is cleared and the state moves to unpack.
  - A stb held without ack causes no transfer.
- unpack: split into sign s, biased exponent E[7:0], mantissa m[22:0]. Unbiased e = E - 127, held in 10-bit signed.
- special_cases (priority order):
  - E = 255, m != 0 (NaN): z = 0x80000000, invalid = 1.
  - E = 255, m = 0 (infinity): z = 0x7FFFFFFF if s = 0, else 0x80000000; invalid = 1.
  - e >= 31, except exactly -2^31 (s = 1, E = 158, m = 0): saturate as for infinity, invalid = 1.
  - Exactly -2^31 gives z = 0x80000000 with no flags.
  - Zero or denormal (E = 0): z = 0. inexact = 1 if m != 0. ±0 gives 0 with no flags.
  - In all the cases above, go straight to put_z.
  - Otherwise go to convert.
- convert (single-cycle barrel shift):
  - Magnitude M = {1, m} (24 bits).
  - e >= 23: M << (e - 23), no fraction bits.
  - 0 <= e < 23: M >> (23 - e). Capture guard = first bit shifted out; sticky = OR of the remaining shifted-out bits.
  - e < 0: integer part 0. guard = 1 if e = -1, else 0. sticky = (m != 0) if e = -1, else 1.
- pack:
  - inexact = guard | sticky.
  - If ROUND_NEAREST = 1: increment the magnitude when guard & (sticky | mag[0]).
  - If s = 1, negate (two's complement). A result of magnitude 0 with s = 1 yields 0.
  - Rounding cannot overflow, because e <= 30 leaves no fraction bits at the top range. A defensive saturate to 0x7FFFFFFF / invalid is still required if the rounded magnitude exceeds 2^31 - 1 for s = 0.
- put_z:
  - output_z_stb = 1 and result/flags are registered on the first edge in put_z.
  - Transfer on the edge where output_z_stb = 1 and output_z_ack = 1. On that edge stb is cleared and the state returns to get_a.
  - output_z and flags stay stable while stb = 1 and ack = 0.
- Latency:
  - Normal path: 4 edges from input transfer to output_z_stb rising (unpack, special_cases, convert, pack, then stb set on entering put_z).
  - Special path: 2 edges (unpack, special_cases).
- Throughput: one conversion in flight. input_a_ack stays 0 from input transfer until the return to get_a.
- Simultaneous events:
  - output_z_ack arriving in the same cycle stb first rises is not a transfer. Ack is sampled against the registered stb.
  - input_a_stb asserted during the busy phases is ignored.

Decomposition:
- Package fp32_pkg holds:
  - FP32_EXP_BIAS = 127, FP32_EXP_MAX = 255, FP32_MANT_W = 23.
  - INT32_MAX = 0x7FFFFFFF, INT32_MIN = 0x80000000.
  - The 3-bit state encoding constants.
- One natural combinational sub-module: fp32_align_shifter. It takes a 24-bit mantissa and signed exponent and returns the 32-bit integer part, guard and sticky.
- All sequencing stays in the top module.

Test Plan:
- 0x3F800000 (1.0), ack held 1 -> output_z = 0x00000001, no flags; stb rises exactly 4 edges after input transfer.
- 0x40600000 (3.5) -> ROUND_NEAREST = 0: 0x00000003, inexact = 1. ROUND_NEAREST = 1: 0x00000004, inexact = 1.
- 0xC0200000 (-2.5) -> both modes: 0xFFFFFFFE, inexact = 1 (tie rounds to even 2).
- Specials:
  - 0x7FC00000 (NaN) -> 0x80000000, invalid = 1.
  - 0x4F000000 (2^31) -> 0x7FFFFFFF, invalid = 1.
  - 0xCF000000 (-2^31) -> 0x80000000, no flags.
  - 0x80000000 (-0) -> 0, no flags.
  - 0x00000001 (denormal) -> 0, inexact = 1.
- Backpressure: hold output_z_ack = 0 for 5 cycles after stb -> output_z / flags / stb stable and input_a_ack = 0 throughout. Ack 1 -> stb falls next edge, input_a_ack returns 1 one edge later.
- Reset: assert reset = 0 asynchronously during convert for less than one clock period -> stb, ack, output_z and flags all 0 immediately. After release, the next operand 0x41200000 (10.0) -> 0x0000000A.
